// File: rtl/hc245_bus_arbiter_if.sv
// ============================================================================
// Module  : hc245_bus_arbiter_if
// Purpose : Request/grant and transceiver pin bundle for hc245_bus_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hc245_bus_arbiter_if;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic dir;
    logic oe_n;

    modport master (
        output req_a, req_b,
        input  gnt_a, gnt_b, dir, oe_n
    );

    modport slave (
        input  req_a, req_b,
        output gnt_a, gnt_b, dir, oe_n
    );
endinterface

`default_nettype wire

// File: rtl/hc245_bus_arbiter.sv
// ============================================================================
// Module  : hc245_bus_arbiter
// Purpose : Round-robin owner arbitration and DIR / OE_n sequencing for a
//           shared 74HC245, with dead time around every direction change.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hc245_bus_arbiter #(
    parameter int TURN     = 2,
    parameter int SETTLE   = 1,
    parameter int MAX_HOLD = 16
) (
    input  wire                      clk,
    input  wire                      rst_n,
    hc245_bus_arbiter_if.slave       bus
);

    localparam int MAX_TS = (TURN > SETTLE) ? TURN : SETTLE;
    localparam int CNT_W  = (MAX_TS > 0) ? $clog2(MAX_TS + 1) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [CNT_W-1:0]  TURN_LAST   = CNT_W'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_OWN    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                dir_q, dir_d;
    logic                oe_n_q, oe_n_d;
    logic                gnt_a_q, gnt_a_d;
    logic                gnt_b_q, gnt_b_d;
    logic                last_b_q, last_b_d;   // 1: B owned last
    logic                win_b_q, win_b_d;     // 1: B is the current winner

    logic pick_b;
    logic tgt_dir;
    logic win_req;
    logic other_req;
    logic preempt;

    always_comb begin
        // On a tie the master that did not own the bus last wins.
        pick_b    = bus.req_b & (~bus.req_a | ~last_b_q);
        tgt_dir   = ~pick_b;
        win_req   = win_b_q ? bus.req_b : bus.req_a;
        other_req = win_b_q ? bus.req_a : bus.req_b;
        preempt   = (MAX_HOLD > 0) && other_req && (hold_q >= HOLD_LAST);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        dir_d    = dir_q;
        oe_n_d   = oe_n_q;
        gnt_a_d  = gnt_a_q;
        gnt_b_d  = gnt_b_q;
        last_b_d = last_b_q;
        win_b_d  = win_b_q;

        case (state_q)
            ST_IDLE: begin
                oe_n_d  = 1'b1;
                gnt_a_d = 1'b0;
                gnt_b_d = 1'b0;
                cnt_d   = '0;
                hold_d  = '0;
                if (bus.req_a || bus.req_b) begin
                    win_b_d = pick_b;
                    dir_d   = tgt_dir;
                    if ((tgt_dir != dir_q) && (TURN > 0)) begin
                        state_d = ST_TURN;
                    end else begin
                        oe_n_d = 1'b0;
                        if (SETTLE == 0) begin
                            state_d = ST_OWN;
                            gnt_a_d = ~pick_b;
                            gnt_b_d = pick_b;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end
                end
            end

            ST_TURN: begin
                oe_n_d = 1'b1;
                if (!win_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TURN_LAST) begin
                    cnt_d  = '0;
                    oe_n_d = 1'b0;
                    if (SETTLE == 0) begin
                        state_d = ST_OWN;
                        gnt_a_d = ~win_b_q;
                        gnt_b_d = win_b_q;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (!win_req) begin
                    state_d = ST_IDLE;
                    oe_n_d  = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_OWN;
                    cnt_d   = '0;
                    gnt_a_d = ~win_b_q;
                    gnt_b_d = win_b_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_OWN: begin
                if (!win_req || preempt) begin
                    state_d  = ST_IDLE;
                    gnt_a_d  = 1'b0;
                    gnt_b_d  = 1'b0;
                    oe_n_d   = 1'b1;
                    last_b_d = win_b_q;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                oe_n_d  = 1'b1;
                gnt_a_d = 1'b0;
                gnt_b_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            dir_q    <= 1'b0;
            oe_n_q   <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            last_b_q <= 1'b1;
            win_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            dir_q    <= dir_d;
            oe_n_q   <= oe_n_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= last_b_d;
            win_b_q  <= win_b_d;
        end
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.dir   = dir_q;
    assign bus.oe_n  = oe_n_q;

endmodule

`default_nettype wire

// File: tb/tb_hc245_bus_arbiter.sv
// ============================================================================
// Module  : tb_hc245_bus_arbiter
// Purpose : Directed self-checking bench for hc245_bus_arbiter (TURN=2,
//           SETTLE=1, MAX_HOLD=16); outputs checked as {gnt_a,gnt_b,dir,oe_n}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hc245_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic mon_en = 1'b0;
    logic prev_dir = 1'b0;
    logic prev_oe = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   n;

    hc245_bus_arbiter_if bus();

    hc245_bus_arbiter #(
        .TURN     (2),
        .SETTLE   (1),
        .MAX_HOLD (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_bus(input string tag, input logic [3:0] exp);
        chk(tag, 32'({bus.gnt_a, bus.gnt_b, bus.dir, bus.oe_n}), 32'(exp));
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Per-cycle pin safety invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("gnt_mutex", 32'(bus.gnt_a & bus.gnt_b), 32'd0);
            if (bus.gnt_a) chk("gnt_a_pins", 32'({bus.oe_n, bus.dir}), 32'd1);
            if (bus.gnt_b) chk("gnt_b_pins", 32'({bus.oe_n, bus.dir}), 32'd0);
            if (bus.dir !== prev_dir) chk("dir_under_oe", 32'({prev_oe, bus.oe_n}), 32'd3);
        end
        prev_dir = bus.dir;
        prev_oe  = bus.oe_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        cyc(); cyc();
        exp_bus("reset", 4'b0001);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        cyc(); exp_bus("idle", 4'b0001);

        // A from reset: direction change, then release with B waiting
        bus.req_a = 1'b1;
        cyc(); exp_bus("a_e0", 4'b0011);
        cyc(); exp_bus("a_e1", 4'b0011);
        cyc(); exp_bus("a_e2", 4'b0010);
        cyc(); exp_bus("a_e3", 4'b1010);
        cyc(); exp_bus("a_own", 4'b1010);
        bus.req_b = 1'b1;
        cyc(); exp_bus("a_own_breq", 4'b1010);
        bus.req_a = 1'b0;
        cyc(); exp_bus("a_rel", 4'b0011);
        cyc(); exp_bus("b_e0", 4'b0001);
        cyc(); exp_bus("b_e1", 4'b0001);
        cyc(); exp_bus("b_e2", 4'b0000);
        cyc(); exp_bus("b_e3", 4'b0100);
        bus.req_b = 1'b0;
        cyc(); exp_bus("b_rel", 4'b0001);

        // Tie after B owned: A wins, then alternate under the hold limit
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        cyc(); exp_bus("tie_e0", 4'b0011);
        cyc(); exp_bus("tie_e1", 4'b0011);
        cyc(); exp_bus("tie_e2", 4'b0010);
        cyc(); exp_bus("tie_e3", 4'b1010);
        n = 1;
        for (int i = 0; i < 40 && bus.gnt_a; i++) begin
            cyc();
            if (bus.gnt_a) n++;
        end
        chk("a_hold_len", 32'(n), 32'd16);
        exp_bus("pre_a_idle", 4'b0011);
        cyc(); exp_bus("pb_e0", 4'b0001);
        cyc(); exp_bus("pb_e1", 4'b0001);
        cyc(); exp_bus("pb_e2", 4'b0000);
        cyc(); exp_bus("pb_e3", 4'b0100);
        n = 1;
        for (int i = 0; i < 40 && bus.gnt_b; i++) begin
            cyc();
            if (bus.gnt_b) n++;
        end
        chk("b_hold_len", 32'(n), 32'd16);
        exp_bus("pre_b_idle", 4'b0001);
        cyc(); exp_bus("alt_a_e0", 4'b0011);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        cyc(); exp_bus("turn_abort", 4'b0011);

        // B grant to bring dir back to 0
        bus.req_b = 1'b1;
        cyc(); exp_bus("b2_e0", 4'b0001);
        cyc(); exp_bus("b2_e1", 4'b0001);
        cyc(); exp_bus("b2_e2", 4'b0000);
        cyc(); exp_bus("b2_e3", 4'b0100);
        bus.req_b = 1'b0;
        cyc(); exp_bus("b2_rel", 4'b0001);

        // One-cycle req_a pulse aborts in TURN; dir stays 1
        bus.req_a = 1'b1;
        cyc(); exp_bus("ab_e0", 4'b0011);
        bus.req_a = 1'b0;
        cyc(); exp_bus("ab_e1", 4'b0011);
        cyc(); exp_bus("ab_e2", 4'b0011);
        cyc(); exp_bus("ab_e3", 4'b0011);

        // Same direction: oe_n at edge 0, grant after SETTLE
        bus.req_a = 1'b1;
        cyc(); exp_bus("nd_e0", 4'b0010);
        cyc(); exp_bus("nd_e1", 4'b1010);
        bus.req_a = 1'b0;
        cyc(); exp_bus("nd_rel", 4'b0011);

        // Reset while B owns, then full-latency A grant
        bus.req_b = 1'b1;
        cyc(); exp_bus("r_e0", 4'b0001);
        cyc(); exp_bus("r_e1", 4'b0001);
        cyc(); exp_bus("r_e2", 4'b0000);
        cyc(); exp_bus("r_e3", 4'b0100);
        rst_n     = 1'b0;
        bus.req_b = 1'b0;
        cyc(); exp_bus("rst_mid", 4'b0001);
        rst_n     = 1'b1;
        bus.req_a = 1'b1;
        cyc(); exp_bus("ra_e0", 4'b0011);
        cyc(); exp_bus("ra_e1", 4'b0011);
        cyc(); exp_bus("ra_e2", 4'b0010);
        cyc(); exp_bus("ra_e3", 4'b1010);
        bus.req_a = 1'b0;
        cyc(); exp_bus("ra_rel", 4'b0011);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
